tone_gen_poly: RTL

Parametrised square-wave note generator for the digital piano. It replaces the one-module-per-note dividers with a single block that takes a note index (C..B) and an octave. Half-period divisors are computed at elaboration from CLK_HZ and an octave-4 frequency table. Note changes are glitch-free, and a key release finishes the current high phase before the output goes silent. The output drives the speaker pin directly.

---
 rtl/tone_gen_poly.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tone_gen_poly.sv
// Square-wave note generator: note index + octave select a half-period divisor,
// note changes land on half-period boundaries and releases finish the high phase.
module tone_gen_poly #(
  parameter int unsigned CLK_HZ   = 50000000,
  parameter int unsigned DIV_W    = 21,
  parameter int unsigned BASE_OCT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_on,
  input  logic [3:0] note_sel,
  input  logic [2:0] octave,
  output logic       tone_out,
  output logic       playing,
  output logic [3:0] cur_note,
  output logic [2:0] cur_oct
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_STOP = 2'd2
  } state_t;

  // Every arm is a constant expression, so this folds into a 12-entry ROM.
  function automatic logic [31:0] base_div(input logic [3:0] n);
    case (n)
      4'd0:    base_div = 32'(CLK_HZ / 524);
      4'd1:    base_div = 32'(CLK_HZ / 554);
      4'd2:    base_div = 32'(CLK_HZ / 588);
      4'd3:    base_div = 32'(CLK_HZ / 622);
      4'd4:    base_div = 32'(CLK_HZ / 660);
      4'd5:    base_div = 32'(CLK_HZ / 698);
      4'd6:    base_div = 32'(CLK_HZ / 740);
      4'd7:    base_div = 32'(CLK_HZ / 784);
      4'd8:    base_div = 32'(CLK_HZ / 830);
      4'd9:    base_div = 32'(CLK_HZ / 880);
      4'd10:   base_div = 32'(CLK_HZ / 932);
      4'd11:   base_div = 32'(CLK_HZ / 988);
      default: base_div = 32'd0;
    endcase
  endfunction

  function automatic logic [DIV_W-1:0] clamp_div(input logic [63:0] raw);
    logic [DIV_W-1:0] t;
    t = raw[DIV_W-1:0];
    if (t < DIV_W'(2)) t = DIV_W'(2);
    return t;
  endfunction

  function automatic logic [DIV_W-1:0] scaled_div(input logic [3:0] n, input logic [2:0] oct);
    logic [63:0] b;
    b = {32'd0, base_div(n)};
    if (32'(oct) > BASE_OCT) b = b >> (32'(oct) - BASE_OCT);
    else                     b = b << (BASE_OCT - 32'(oct));
    return clamp_div(b);
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tone_q, tone_d;
  logic             playing_q, playing_d;
  logic [3:0]       cur_note_q, cur_note_d;
  logic [2:0]       cur_oct_q, cur_oct_d;

  logic             req_valid;
  logic             at_end;
  logic [DIV_W-1:0] new_div;

  assign req_valid = key_on && (note_sel < 4'd12);
  assign new_div   = scaled_div(note_sel, octave);
  assign at_end    = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    tone_d     = tone_q;
    cur_note_d = cur_note_q;
    cur_oct_d  = cur_oct_q;
    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        cnt_d  = '0;
        if (req_valid) begin
          state_d    = S_PLAY;
          tone_d     = 1'b1;
          div_d      = new_div;
          cur_note_d = note_sel;
          cur_oct_d  = octave;
        end
      end
      S_PLAY, S_STOP: begin
        if (state_q == S_STOP && !req_valid && !tone_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          tone_d  = 1'b0;
        end else begin
          if (at_end) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // A release on a boundary wins: the old note keeps its divisor.
          if (req_valid) begin
            state_d = S_PLAY;
            if (at_end) begin
              div_d      = new_div;
              cur_note_d = note_sel;
              cur_oct_d  = octave;
            end
          end else if (state_q == S_PLAY) begin
            state_d = S_STOP;
          end else if (at_end) begin
            state_d = S_IDLE;
            tone_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    playing_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      tone_q     <= 1'b0;
      playing_q  <= 1'b0;
      cur_note_q <= 4'd0;
      cur_oct_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tone_q     <= tone_d;
      playing_q  <= playing_d;
      cur_note_q <= cur_note_d;
      cur_oct_q  <= cur_oct_d;
    end
  end

  assign tone_out = tone_q;
  assign playing  = playing_q;
  assign cur_note = cur_note_q;
  assign cur_oct  = cur_oct_q;

endmodule
